// File: rtl/deck_controller.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : deck_controller
// Purpose  : Fills the 52-card deck RAM, lends the RAM port to the shuffler,
//            then serves single-card draws. Optional watchdog: DECK_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module deck_controller #(
  parameter int DECK_SIZE = 52,
  parameter int ADDR_W    = 6,
  parameter int DATA_W    = 4,
  parameter int TIMEOUT   = 4095
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              new_deck,
  input  logic              draw_req,
  output logic [DATA_W-1:0] card,
  output logic              card_valid,
  output logic              ready,
  output logic              deck_empty,
  output logic [ADDR_W-1:0] cards_left,
  output logic              shuf_start,
  input  logic              shuf_finish,
  input  logic [ADDR_W-1:0] shuf_addr,
  input  logic [DATA_W-1:0] shuf_data,
  input  logic              shuf_wren,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_wren,
  input  logic [DATA_W-1:0] ram_q,
  output logic              shuf_err
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FILL    = 3'd1,
    S_SHUFFLE = 3'd2,
    S_READY   = 3'd3,
    S_READ    = 3'd4,
    S_DELIVER = 3'd5
  } state_t;

  localparam logic [ADDR_W-1:0] c_last_addr = ADDR_W'(DECK_SIZE - 1);
  localparam logic [ADDR_W-1:0] c_deck_cnt  = ADDR_W'(DECK_SIZE);
  localparam logic [DATA_W-1:0] c_top_rank  = DATA_W'(13);
  localparam logic [DATA_W-1:0] c_low_rank  = DATA_W'(1);
  localparam int                c_wd_w      = $clog2(TIMEOUT + 1);

  state_t              r_state;
  logic [ADDR_W-1:0]   r_fill_ptr;
  logic [DATA_W-1:0]   r_rank;
  logic [ADDR_W-1:0]   r_draw_ptr;
  logic [DATA_W-1:0]   r_card;
  logic                r_card_valid;
  logic                r_ready;
  logic                r_deck_empty;
  logic [ADDR_W-1:0]   r_cards_left;
  logic                r_shuf_start;

`ifdef DECK_TIMEOUT_EN
  logic [c_wd_w-1:0]   r_wd_cnt;
  logic                r_shuf_err;
  assign shuf_err = r_shuf_err;
`else
  logic [c_wd_w-1:0]   w_unused_timeout;
  assign w_unused_timeout = c_wd_w'(TIMEOUT);
  assign shuf_err         = 1'b0;
`endif

  assign card       = r_card;
  assign card_valid = r_card_valid;
  assign ready      = r_ready;
  assign deck_empty = r_deck_empty;
  assign cards_left = r_cards_left;
  assign shuf_start = r_shuf_start;

  // The shuffler owns the port combinationally for the whole of SHUFFLE.
  always_comb begin
    ram_addr = r_draw_ptr;
    ram_data = '0;
    ram_wren = 1'b0;
    case (r_state)
      S_FILL: begin
        ram_addr = r_fill_ptr;
        ram_data = r_rank;
        ram_wren = 1'b1;
      end
      S_SHUFFLE: begin
        ram_addr = shuf_addr;
        ram_data = shuf_data;
        ram_wren = shuf_wren;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_fill_ptr   <= '0;
      r_rank       <= c_low_rank;
      r_draw_ptr   <= '0;
      r_card       <= '0;
      r_card_valid <= 1'b0;
      r_ready      <= 1'b0;
      r_deck_empty <= 1'b1;
      r_cards_left <= '0;
      r_shuf_start <= 1'b0;
`ifdef DECK_TIMEOUT_EN
      r_wd_cnt     <= '0;
      r_shuf_err   <= 1'b0;
`endif
    end else begin
      r_card_valid <= 1'b0;
`ifdef DECK_TIMEOUT_EN
      r_shuf_err   <= 1'b0;
`endif
      case (r_state)
        S_IDLE: begin
          if (new_deck) begin
            r_fill_ptr <= '0;
            r_rank     <= c_low_rank;
            r_state    <= S_FILL;
          end
        end
        S_FILL: begin
          r_fill_ptr <= r_fill_ptr + 1'b1;
          r_rank     <= (r_rank == c_top_rank) ? c_low_rank : r_rank + 1'b1;
          if (r_fill_ptr == c_last_addr) begin
            r_shuf_start <= 1'b1;
            r_state      <= S_SHUFFLE;
`ifdef DECK_TIMEOUT_EN
            r_wd_cnt     <= '0;
`endif
          end
        end
        S_SHUFFLE: begin
          if (shuf_finish) begin
            r_shuf_start <= 1'b0;
            r_ready      <= 1'b1;
            r_draw_ptr   <= '0;
            r_cards_left <= c_deck_cnt;
            r_deck_empty <= 1'b0;
            r_state      <= S_READY;
          end
`ifdef DECK_TIMEOUT_EN
          else if (r_wd_cnt == c_wd_w'(TIMEOUT - 1)) begin
            r_shuf_start <= 1'b0;
            r_shuf_err   <= 1'b1;
            r_state      <= S_IDLE;
          end else begin
            r_wd_cnt <= r_wd_cnt + 1'b1;
          end
`endif
        end
        S_READY: begin
          // A new deck discards whatever is left of the current one.
          if (new_deck) begin
            r_ready      <= 1'b0;
            r_cards_left <= '0;
            r_deck_empty <= 1'b1;
            r_fill_ptr   <= '0;
            r_rank       <= c_low_rank;
            r_state      <= S_FILL;
          end else if (draw_req && (r_cards_left != '0)) begin
            r_ready <= 1'b0;
            r_state <= S_READ;
          end
        end
        S_READ: begin
          r_state <= S_DELIVER;
        end
        S_DELIVER: begin
          r_card       <= ram_q;
          r_card_valid <= 1'b1;
          r_draw_ptr   <= r_draw_ptr + 1'b1;
          r_cards_left <= r_cards_left - 1'b1;
          r_deck_empty <= (r_cards_left == ADDR_W'(1));
          r_ready      <= 1'b1;
          r_state      <= S_READY;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_deck_controller.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_deck_controller
// Purpose  : Directed + randomized self-checking bench for deck_controller.
// Revision : 1.0 - initial release
// ============================================================================
module tb_deck_controller;

  localparam int DS = 52;

  logic       clock = 1'b0;
  logic       reset, new_deck, draw_req;
  logic [3:0] card;
  logic       card_valid, ready, deck_empty;
  logic [5:0] cards_left;
  logic       shuf_start, shuf_finish;
  logic [5:0] shuf_addr;
  logic [3:0] shuf_data;
  logic       shuf_wren;
  logic [5:0] ram_addr;
  logic [3:0] ram_data;
  logic       ram_wren;
  logic [3:0] ram_q;
  logic       shuf_err;

  always #5 clock = ~clock;

  deck_controller #(
    .DECK_SIZE(52), .ADDR_W(6), .DATA_W(4), .TIMEOUT(100)
  ) dut (
    .clock(clock), .reset(reset), .new_deck(new_deck), .draw_req(draw_req),
    .card(card), .card_valid(card_valid), .ready(ready), .deck_empty(deck_empty),
    .cards_left(cards_left), .shuf_start(shuf_start), .shuf_finish(shuf_finish),
    .shuf_addr(shuf_addr), .shuf_data(shuf_data), .shuf_wren(shuf_wren),
    .ram_addr(ram_addr), .ram_data(ram_data), .ram_wren(ram_wren),
    .ram_q(ram_q), .shuf_err(shuf_err)
  );

  // Deck RAM: registered read, one edge of latency.
  logic [3:0] mem [64];
  always @(posedge clock) begin
    if (ram_wren) mem[ram_addr] <= ram_data;
    ram_q <= mem[ram_addr];
  end

  int n_assert = 0;
  int n_fail   = 0;
  int exp_deck [64];
  int next_card;
  int bad;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Entered on the first FILL cycle; leaves on the first SHUFFLE cycle.
  task automatic fill_check();
    for (int i = 0; i < DS; i++) begin
      check("fill_wren", ram_wren, 1);
      check("fill_addr", ram_addr, i);
      check("fill_data", ram_data, (i % 13) + 1);
      exp_deck[i] = (i % 13) + 1;
      tick();
    end
    check("shuf_start_rise", shuf_start, 1);
    check("ready_in_shuffle", ready, 0);
  endtask

  task automatic shuffle(input int len, input bit allow_wr, input bit seed7);
    for (int k = 0; k < len; k++) begin
      shuf_addr   = 6'($urandom_range(seed7 ? 1 : 0, 63));
      shuf_data   = 4'($urandom);
      shuf_wren   = allow_wr ? 1'($urandom_range(0, 1)) : 1'b0;
      if (seed7 && k == 0) begin
        shuf_addr = 6'd0;
        shuf_data = 4'd7;
        shuf_wren = 1'b1;
      end
      shuf_finish = (k == len - 1);
      if (shuf_finish) shuf_wren = 1'b0;
      #1;
      check("mux_addr", ram_addr, shuf_addr);
      check("mux_data", ram_data, shuf_data);
      check("mux_wren", ram_wren, shuf_wren);
      check("shuf_start_hold", shuf_start, 1);
      if (shuf_wren) exp_deck[shuf_addr] = shuf_data;
      tick();
    end
    shuf_finish = 1'b0;
    shuf_wren   = 1'b0;
    check("ready_after_finish", ready, 1);
    check("shuf_start_drop", shuf_start, 0);
    check("cards_left_full", cards_left, DS);
    check("deck_empty_full", deck_empty, 0);
    next_card = 0;
  endtask

  task automatic draw_one();
    draw_req = 1'b1;
    tick();
    check("draw_e0_ready", ready, 0);
    check("draw_e0_valid", card_valid, 0);
    draw_req = 1'b0;
    tick();
    check("draw_e1_ready", ready, 0);
    check("draw_e1_valid", card_valid, 0);
    tick();
    check("draw_e2_valid", card_valid, 1);
    check("draw_card", card, exp_deck[next_card]);
    next_card++;
    check("draw_left", cards_left, DS - next_card);
    check("draw_empty", deck_empty, (next_card == DS) ? 1 : 0);
    check("draw_ready_back", ready, 1);
    tick();
    check("valid_pulse_end", card_valid, 0);
  endtask

  task automatic draw_burst(input int n);
    draw_req = 1'b1;
    for (int j = 0; j < n; j++) begin
      tick();
      check("burst_gap1", card_valid, 0);
      tick();
      check("burst_gap2", card_valid, 0);
      tick();
      check("burst_valid", card_valid, 1);
      check("burst_card", card, exp_deck[next_card]);
      next_card++;
      check("burst_left", cards_left, DS - next_card);
    end
    draw_req = 1'b0;
    tick();
    check("burst_end", card_valid, 0);
  endtask

  initial begin
    reset = 1'b1; new_deck = 1'b0; draw_req = 1'b0;
    shuf_finish = 1'b0; shuf_addr = '0; shuf_data = '0; shuf_wren = 1'b0;
    repeat (3) tick();
    check("rst_card", card, 0);
    check("rst_valid", card_valid, 0);
    check("rst_ready", ready, 0);
    check("rst_empty", deck_empty, 1);
    check("rst_left", cards_left, 0);
    check("rst_shuf_start", shuf_start, 0);
    check("rst_ram_wren", ram_wren, 0);
    check("rst_ram_addr", ram_addr, 0);
    check("rst_ram_data", ram_data, 0);
    check("rst_shuf_err", shuf_err, 0);
    reset = 1'b0;
    draw_req = 1'b1;
    tick();
    check("idle_ignores_draw", card_valid, 0);
    draw_req = 1'b0;

    // Round 1: identity shuffle, draw the whole deck.
    new_deck = 1'b1; tick(); new_deck = 1'b0;
    fill_check();
    shuffle(10, 1'b0, 1'b0);
    draw_burst(6);
    for (int d = 6; d < DS; d++) draw_one();
    check("empty_after_52", deck_empty, 1);
    draw_req = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("draw53_no_valid", card_valid, 0);
      check("draw53_ready", ready, 1);
    end
    draw_req = 1'b0;

    // Round 2: random shuffle writes with addr 0 forced to 7.
    new_deck = 1'b1; tick(); new_deck = 1'b0;
    fill_check();
    shuffle($urandom_range(5, 20), 1'b1, 1'b1);
    draw_one();
    check("first_draw_7", card, 7);
    for (int d = 1; d < 22; d++) draw_one();
    check("left_30", cards_left, 30);

    // new_deck wins over a simultaneous draw.
    new_deck = 1'b1; draw_req = 1'b1;
    tick();
    new_deck = 1'b0; draw_req = 1'b0;
    check("nd_win_valid", card_valid, 0);
    check("nd_win_ready", ready, 0);
    check("nd_win_left", cards_left, 0);
    fill_check();
    shuffle($urandom_range(3, 12), 1'b1, 1'b0);
    for (int d = 0; d < int'($urandom_range(1, 5)); d++) draw_one();

    // Reset mid-FILL.
    new_deck = 1'b1; tick(); new_deck = 1'b0;
    repeat (20) tick();
    check("midfill_ptr", ram_addr, 20);
    reset = 1'b1; tick(); reset = 1'b0;
    check("rf_shuf_start", shuf_start, 0);
    check("rf_ram_wren", ram_wren, 0);
    check("rf_empty", deck_empty, 1);
    check("rf_ready", ready, 0);
    check("rf_left", cards_left, 0);

    // Reset mid-SHUFFLE.
    new_deck = 1'b1; tick(); new_deck = 1'b0;
    fill_check();
    repeat (3) tick();
    check("ms_start_high", shuf_start, 1);
    reset = 1'b1; tick(); reset = 1'b0;
    check("rs_shuf_start", shuf_start, 0);
    check("rs_ram_wren", ram_wren, 0);
    check("rs_empty", deck_empty, 1);
    check("rs_ready", ready, 0);

    // Shuffler that never finishes.
    new_deck = 1'b1; tick(); new_deck = 1'b0;
    fill_check();
    bad = 0;
`ifdef DECK_TIMEOUT_EN
    for (int k = 0; k < 99; k++) begin
      tick();
      if (shuf_start !== 1'b1 || shuf_err !== 1'b0) bad++;
    end
    check("wd_hold", bad, 0);
    tick();
    check("wd_err_pulse", shuf_err, 1);
    check("wd_start_drop", shuf_start, 0);
    check("wd_ready", ready, 0);
    check("wd_left", cards_left, 0);
    check("wd_ram_wren", ram_wren, 0);
    tick();
    check("wd_err_one_cycle", shuf_err, 0);
`else
    for (int k = 0; k < 10000; k++) begin
      tick();
      if (shuf_start !== 1'b1 || shuf_err !== 1'b0 || ready !== 1'b0) bad++;
    end
    check("no_wd_wait", bad, 0);
    check("no_wd_start", shuf_start, 1);
    reset = 1'b1; tick(); reset = 1'b0;
    check("no_wd_reset", shuf_start, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/deck_controller.md
# deck_controller

Sequencer and RAM-port owner for the 52-card deck memory (64×4 RAM). It fills the RAM with an ordered deck, hands the RAM port to the shuffler for the duration of its start/finish handshake, then serves single-card draw requests from the top of the shuffled deck. It sits between the game FSM and the deck RAM, and is the only block driving the RAM port.

## Interface
Parameters:
- DECK_SIZE, 52, number of cards written and drawable.
- ADDR_W, 6, RAM address width.
- DATA_W, 4, card value width.
- TIMEOUT, 4095, shuffle watchdog limit in cycles (used only with DECK_TIMEOUT_EN).

Ports:
- clock  in  1  single clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high.
- new_deck  in  1  request fill + shuffle; sampled only in IDLE or READY.
- draw_req  in  1  request one card; sampled only in READY.
- card  out  DATA_W  drawn card value (1..13), held until the next draw.
- card_valid  out  1  one-cycle pulse: card is new.
- ready  out  1  high in READY.
- deck_empty  out  1  high when cards_left == 0.
- cards_left  out  ADDR_W  undrawn cards remaining.
- shuf_start  out  1  to the shuffler's start; high for the whole of SHUFFLE.
- shuf_finish  in  1  from the shuffler's finish.
- shuf_addr  in  ADDR_W, shuf_data  in  DATA_W, shuf_wren  in  1  shuffler's RAM request.
- ram_addr  out  ADDR_W, ram_data  out  DATA_W, ram_wren  out  1  RAM port.
- ram_q  in  DATA_W  RAM read data, valid one edge after ram_addr is presented.
- shuf_err  out  1  watchdog abort pulse (constant 0 without DECK_TIMEOUT_EN).

## Operation
States: IDLE, FILL, SHUFFLE, READY, READ, DELIVER.
- IDLE: new_deck -> FILL, with fill_ptr = 0 and rank = 1.
- FILL: ram_addr = fill_ptr, ram_data = rank, ram_wren = 1.
  - Each cycle fill_ptr increments; rank counts 1..13 and wraps to 1.
  - After address DECK_SIZE-1 is written -> SHUFFLE.
  - Resulting deck: addr i holds (i mod 13)+1.
- SHUFFLE: shuf_start = 1. RAM port is a combinational mux: ram_addr/ram_data/ram_wren = shuf_addr/shuf_data/shuf_wren.
  - shuf_finish = 1 -> READY, with draw_ptr = 0 and cards_left = DECK_SIZE.
  - shuf_start drops on the same edge.
- READY:
  - new_deck has priority -> FILL; any remaining deck is discarded.
  - Otherwise, draw_req with cards_left > 0 -> READ.
  - draw_req with cards_left == 0 is ignored: no pulse, no state change.
- READ: ram_addr = draw_ptr, ram_wren = 0 -> DELIVER.
- DELIVER: card <= ram_q, card_valid <= 1, draw_ptr += 1, cards_left -= 1 -> READY.
- Outside SHUFFLE, ram_addr defaults to draw_ptr, ram_data to 0, ram_wren to 0.
- Arithmetic: all pointers are ADDR_W unsigned. draw_ptr never exceeds DECK_SIZE. cards_left never underflows (guarded by the READY check).
- Reset, in any state including mid-FILL or mid-SHUFFLE: -> IDLE on the next edge. RAM contents become don't-care.
- Reset values: card 0, card_valid 0, ready 0, deck_empty 1, cards_left 0, shuf_start 0, ram_wren 0, ram_addr 0, ram_data 0, shuf_err 0.

## Timing
- Fill: exactly DECK_SIZE write cycles. shuf_start rises on the edge after the last write.
- Shuffle: duration is set by the shuffler. Ready rises on the edge that samples shuf_finish = 1.
- Draw latency: draw_req sampled at edge E0.
  - E1: READ -> DELIVER.
  - E2: card and card_valid update, state returns to READY.
  - card_valid is high for exactly one cycle after E2; ready is low between E0 and E2.
- Continuous draw_req yields one card every 3 cycles.
- deck_empty rises together with the card_valid of the last card.
- new_deck and draw_req in the same READY cycle: new_deck wins, and no card is produced.

## Configuration
- DECK_TIMEOUT_EN defined:
  - A cycle counter runs in SHUFFLE.
  - If shuf_finish is not seen within TIMEOUT cycles: shuf_start drops, state -> IDLE, shuf_err pulses for one cycle, cards_left stays 0.
- Not defined: no counter, SHUFFLE waits indefinitely, shuf_err tied to 0.

## Test plan
- Reset, then new_deck with the shuffler model holding RAM unchanged and raising finish after 10 cycles -> 52 fill writes (addr 0 = 1, addr 12 = 13, addr 13 = 1, addr 51 = 13); ready rises; cards_left = 52.
- 52 draws after an identity shuffle -> cards 1,2..13,1.. in order, each card_valid pulse 2 edges after the request edge. After the 52nd: deck_empty = 1; a 53rd draw_req gives no card_valid.
- During SHUFFLE, the shuffler model writes addr 0 = 7 -> ram port mirrors shuf_* each cycle; the first draw returns 7.
- new_deck and draw_req asserted together in READY with cards_left = 30 -> no card_valid; FILL starts; cards_left = 52 after the next finish.
- Reset asserted mid-FILL (fill_ptr = 20) and again mid-SHUFFLE -> next cycle IDLE, shuf_start = 0, ram_wren = 0, deck_empty = 1.
- With DECK_TIMEOUT_EN and TIMEOUT = 100, finish never raised -> shuf_err pulses once after 100 SHUFFLE cycles; state IDLE; without the macro, the block still waits after 10000 cycles.
